// File: rtl/glb_pkg.sv
// glb_pkg: shared constants, event-word field offsets and FSM state encoding
// for the global event buffer path.
package glb_pkg;
    localparam int ENTRY_W   = 72;
    localparam int N_NBR     = 16;
    localparam int N_PIX     = 12000;
    localparam int PIX_W     = $clog2(N_PIX);
    localparam int VALID_BIT = 71;
    localparam int TS_MSB    = 70;
    localparam int TS_LSB    = 39;
    localparam int IDX_MSB   = 38;
    localparam int IDX_LSB   = 25;
    typedef enum logic [2:0] {IDLE, RD, CAP_WR, EMIT, DONE} state_t;
endpackage

// File: rtl/nbr_prio_enc.sv
// nbr_prio_enc: combinational lowest-set-bit encoder.
// Ports: req (request vector), idx (index of lowest set bit, 0 when none),
//        any (some bit set), only_one (exactly one bit set).
module nbr_prio_enc
    import glb_pkg::*;
#(
    parameter int N = N_NBR
)(
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any,
    output logic                 only_one
);
    localparam int W = $clog2(N);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[k]) idx = W'(k);
    end

    assign any      = |req;
    assign only_one = any && ((req & (req - 1'b1)) == '0);
endmodule

// File: rtl/glb_buf_nbr_reader.sv
// glb_buf_nbr_reader: accepts one event, reads its 16 buffer neighbours, writes
// the event back, then streams in-window neighbours out as edges.
// Ports: clk/rstn; ev_valid/ev_ready/ev_data event input; buf_pixel_idx/buf_en/
//        buf_wr_rdn/buf_din/buf_dout buffer port; edge_valid/edge_ready/
//        edge_nbr/edge_slot/edge_last edge stream; ev_done/ev_nedges status.
module glb_buf_nbr_reader #(
    parameter int          N_PIX   = glb_pkg::N_PIX,
    parameter int          ENTRY_W = glb_pkg::ENTRY_W,
    parameter int          N_NBR   = glb_pkg::N_NBR,
    parameter logic [31:0] T_WIN   = 32'd50000
)(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ev_valid,
    output logic                       ev_ready,
    input  logic [ENTRY_W-1:0]         ev_data,
    output logic [$clog2(N_PIX)-1:0]   buf_pixel_idx,
    output logic                       buf_en,
    output logic                       buf_wr_rdn,
    output logic [ENTRY_W-1:0]         buf_din,
    input  logic [N_NBR*ENTRY_W-1:0]   buf_dout,
    output logic                       edge_valid,
    input  logic                       edge_ready,
    output logic [ENTRY_W-1:0]         edge_nbr,
    output logic [$clog2(N_NBR)-1:0]   edge_slot,
    output logic                       edge_last,
    output logic                       ev_done,
    output logic [$clog2(N_NBR+1)-1:0] ev_nedges
);
    localparam int PIX_W = $clog2(N_PIX);
    localparam int SLT_W = $clog2(N_NBR);
    localparam int CNT_W = $clog2(N_NBR + 1);

    glb_pkg::state_t            state, nxt;
    logic                       run;
    logic [ENTRY_W-1:0]         ev_reg;
    logic [N_NBR*ENTRY_W-1:0]   nbr_reg;
    logic [N_NBR-1:0]           keep, keep_new;
    logic [CNT_W-1:0]           cnt;
    logic [SLT_W-1:0]           idx;
    logic                       any, only_one;
    logic                       ev_hs, edge_hs;

    nbr_prio_enc #(.N(N_NBR)) u_enc (
        .req      (keep),
        .idx      (idx),
        .any      (any),
        .only_one (only_one)
    );

    // Wrapped 32-bit difference: a neighbour newer than the event wraps to a
    // huge value and falls outside the window.
    always_comb begin
        for (int k = 0; k < N_NBR; k++)
            keep_new[k] = buf_dout[k*ENTRY_W + glb_pkg::VALID_BIT] &&
                (32'(ev_reg[glb_pkg::TS_MSB:glb_pkg::TS_LSB] -
                     buf_dout[k*ENTRY_W + glb_pkg::TS_LSB +: 32]) <= T_WIN);
    end

    always_comb begin
        nxt = state;
        case (state)
            glb_pkg::IDLE:   nxt = ev_hs ? glb_pkg::RD : glb_pkg::IDLE;
            glb_pkg::RD:     nxt = glb_pkg::CAP_WR;
            glb_pkg::CAP_WR: nxt = |keep_new ? glb_pkg::EMIT : glb_pkg::DONE;
            glb_pkg::EMIT:   nxt = (edge_hs && only_one) ? glb_pkg::DONE : glb_pkg::EMIT;
            default:         nxt = glb_pkg::IDLE;
        endcase
    end

    // run holds ev_ready low until the first clock after reset release.
    assign ev_ready      = run && state == glb_pkg::IDLE;
    assign ev_hs         = ev_valid && ev_ready;
    assign buf_en        = state == glb_pkg::RD || state == glb_pkg::CAP_WR;
    assign buf_wr_rdn    = state == glb_pkg::CAP_WR;
    assign buf_pixel_idx = buf_en ? PIX_W'(ev_reg[glb_pkg::IDX_MSB:glb_pkg::IDX_LSB]) : '0;
    assign buf_din       = buf_wr_rdn ? ev_reg : '0;
    assign edge_valid    = state == glb_pkg::EMIT && any;
    assign edge_hs       = edge_valid && edge_ready;
    assign edge_slot     = edge_valid ? idx : '0;
    assign edge_nbr      = edge_valid ? nbr_reg[idx*ENTRY_W +: ENTRY_W] : '0;
    assign edge_last     = edge_valid && only_one;
    assign ev_done       = state == glb_pkg::DONE;
    assign ev_nedges     = ev_done ? cnt : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run     <= 1'b0;
            state   <= glb_pkg::IDLE;
            ev_reg  <= '0;
            nbr_reg <= '0;
            keep    <= '0;
            cnt     <= '0;
        end else begin
            run   <= 1'b1;
            state <= nxt;
            if (ev_hs) ev_reg <= ev_data;
            if (state == glb_pkg::CAP_WR) begin
                nbr_reg <= buf_dout;
                keep    <= keep_new;
            end
            if (edge_hs) begin
                keep[idx] <= 1'b0;
                cnt       <= cnt + 1'b1;
            end
            if (state == glb_pkg::DONE) cnt <= '0;
        end
    end
endmodule

// File: tb/tb_glb_buf_nbr_reader.sv
// tb_glb_buf_nbr_reader: scoreboard bench for glb_buf_nbr_reader with directed
// events and hand-computed keep masks.
module tb_glb_buf_nbr_reader;
    logic          clk = 1'b0;
    logic          rstn;
    logic          ev_valid;
    logic          ev_ready;
    logic [71:0]   ev_data;
    logic [13:0]   buf_pixel_idx;
    logic          buf_en;
    logic          buf_wr_rdn;
    logic [71:0]   buf_din;
    logic [1151:0] buf_dout = '0;
    logic          edge_valid;
    logic          edge_ready = 1'b1;
    logic [71:0]   edge_nbr;
    logic [3:0]    edge_slot;
    logic          edge_last;
    logic          ev_done;
    logic [4:0]    ev_nedges;

    glb_buf_nbr_reader dut (
        .clk(clk), .rstn(rstn), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_data(ev_data), .buf_pixel_idx(buf_pixel_idx), .buf_en(buf_en),
        .buf_wr_rdn(buf_wr_rdn), .buf_din(buf_din), .buf_dout(buf_dout),
        .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_nbr(edge_nbr),
        .edge_slot(edge_slot), .edge_last(edge_last), .ev_done(ev_done),
        .ev_nedges(ev_nedges)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n_edge = 0;
    int lat;
    bit bp = 1'b0;
    bit stall = 1'b0;
    logic [71:0]  img [16];
    logic [86:0]  sq [$];
    logic [76:0]  eq [$];
    logic [4:0]   dq [$];
    logic [86:0]  s_exp;
    logic [76:0]  e_exp, hold;
    logic [4:0]   d_exp;
    logic [172:0] outs;

    assign outs = {ev_ready, buf_pixel_idx, buf_en, buf_wr_rdn, buf_din, edge_valid,
                   edge_nbr, edge_slot, edge_last, ev_done, ev_nedges};

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [71:0] mk(input logic [31:0] ts, input logic [13:0] pix);
        return {1'b1, ts, pix, 25'h0A55A5 ^ {11'h0, pix}};
    endfunction

    function automatic logic [71:0] nb(input logic v, input logic [31:0] ts, input int k);
        return {v, ts, 14'(k + 100), 25'(k * 3 + 1)};
    endfunction

    // Buffer model: the addressed neighbour image appears one cycle after a read strobe.
    always @(posedge clk)
        for (int k = 0; k < 16; k++)
            buf_dout[k*72 +: 72] <= (buf_en && !buf_wr_rdn) ? img[k] : 72'h0;

    // Backpressure driver: toggles edge_ready every cycle while bp is set.
    initial forever begin
        @(posedge clk);
        #1 edge_ready = bp ? !edge_ready : 1'b1;
    end

    // Monitor: pops and compares whenever the DUT presents a strobe, edge or done.
    always @(negedge clk) begin
        if (!rstn) stall = 1'b0;
        else begin
            if (stall) check("stall_hold", {edge_valid, edge_nbr, edge_slot, edge_last}, {1'b1, hold});
            if (buf_en) begin
                if (sq.size() == 0) check("strobe_unexpected", buf_en, 1'b0);
                else begin
                    s_exp = sq.pop_front();
                    check("strobe", {buf_wr_rdn, buf_pixel_idx, buf_wr_rdn ? buf_din : 72'h0}, s_exp);
                end
            end
            if (edge_valid && edge_ready) begin
                n_edge++;
                if (eq.size() == 0) check("edge_unexpected", edge_valid, 1'b0);
                else begin
                    e_exp = eq.pop_front();
                    check("edge", {edge_nbr, edge_slot, edge_last}, e_exp);
                end
            end
            if (ev_done) begin
                if (dq.size() == 0) check("done_unexpected", ev_done, 1'b0);
                else begin
                    d_exp = dq.pop_front();
                    check("nedges", ev_nedges, d_exp);
                end
            end
            stall = edge_valid && !edge_ready;
            hold  = {edge_nbr, edge_slot, edge_last};
        end
    end

    // Issues one event from a negedge; lim caps how many edges (and whether the
    // done pulse) are expected, for runs cut short by reset.
    task automatic send(input logic [31:0] ts, input logic [13:0] pix,
                        input logic [15:0] mask, input int lim);
        logic [71:0] ev;
        int n = 0;
        int pc;
        ev = mk(ts, pix);
        sq.push_back({1'b0, pix, 72'h0});
        sq.push_back({1'b1, pix, ev});
        pc = $countones(mask);
        for (int k = 0; k < 16; k++)
            if (mask[k]) begin
                if (n < lim) eq.push_back({img[k], 4'(k), (mask >> (k + 1)) == 16'h0});
                n++;
            end
        if (lim >= pc) dq.push_back(5'(pc));
        ev_data  = ev;
        ev_valid = 1'b1;
        for (int i = 0; i < 50 && !ev_ready; i++) @(negedge clk);
        check("ev_accept", ev_ready, 1'b1);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        ev_data = '0;
    endtask

    task automatic wait_done(input int max, output int l);
        l = -1;
        for (int i = 1; i <= max && l < 0; i++) begin
            @(negedge clk);
            if (ev_done) l = i;
        end
        check("ev_done_seen", ev_done, 1'b1);
    endtask

    task automatic clear_img();
        for (int k = 0; k < 16; k++) img[k] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rstn = 1'b0;
        ev_valid = 1'b0;
        ev_data = '0;
        clear_img();
        repeat (3) @(negedge clk);
        check("reset_outs", outs, 0);
        rstn = 1'b1;
        #1 check("ready_after_release", ev_ready, 1'b0);
        @(posedge clk);
        #1 check("ready_first_cycle", ev_ready, 1'b1);
        @(negedge clk);

        // Empty buffer
        send(32'd1000, 14'd500, 16'h0000, 16);
        wait_done(20, lat);
        check("lat_empty", lat, 3);

        // Mixed neighbours: slot 7 has matching ts but valid bit clear
        img[2] = nb(1'b1, 32'd900, 2);
        img[5] = nb(1'b1, 32'd1000, 5);
        img[9] = nb(1'b1, 32'd1100, 9);
        img[7] = nb(1'b0, 32'd1000, 7);
        send(32'd1000, 14'd123, 16'h0024, 16);
        wait_done(20, lat);
        check("lat_mixed", lat, 5);

        // Window boundary
        clear_img();
        img[0] = nb(1'b1, 32'd0, 0);
        send(32'd50000, 14'd200, 16'h0001, 16);
        wait_done(20, lat);
        send(32'd50001, 14'd201, 16'h0000, 16);
        wait_done(20, lat);
        check("lat_boundary_rej", lat, 3);

        // Timestamp wrap: slot 3 is older across the wrap, slot 4 is newer by one
        clear_img();
        img[3] = nb(1'b1, 32'hFFFF_FF00, 3);
        img[4] = nb(1'b1, 32'h0000_0101, 4);
        send(32'h0000_0100, 14'd300, 16'h0008, 16);
        wait_done(20, lat);

        // Backpressure with all 16 slots kept
        for (int k = 0; k < 16; k++) img[k] = nb(1'b1, 32'(5000 - k * 10), k);
        bp = 1'b1;
        send(32'd5000, 14'd400, 16'hFFFF, 16);
        wait_done(100, lat);
        bp = 1'b0;
        @(negedge clk);

        // Reset in EMIT after 3 of 6 edges
        clear_img();
        for (int k = 0; k < 6; k++) img[k] = nb(1'b1, 32'd7000, k);
        base = n_edge;
        send(32'd7000, 14'd600, 16'h003F, 3);
        for (int i = 0; i < 50 && n_edge < base + 3; i++) @(posedge clk);
        check("edges_before_reset", n_edge, base + 3);
        #1 rstn = 1'b0;
        #1 check("reset_emit_outs", outs, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("ready_after_rerelease", ev_ready, 1'b0);
        @(posedge clk);
        #1 check("ready_after_reset", ev_ready, 1'b1);
        @(negedge clk);

        // Normal event after reset: count restarts from zero
        clear_img();
        img[2] = nb(1'b1, 32'd900, 2);
        img[5] = nb(1'b1, 32'd1000, 5);
        img[9] = nb(1'b1, 32'd1100, 9);
        send(32'd1000, 14'd124, 16'h0024, 16);
        wait_done(20, lat);
        check("lat_post_reset", lat, 5);

        repeat (5) @(negedge clk);
        check("queues_empty", {sq.size(), eq.size(), dq.size()}, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
